mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one AHB-lite-style master port between the instruction fetch requester (IFU) and the data requester (MAU).
//  Sits between IFU/MAU and the single external memory bus; the core then needs one memory port instead of two.
//  Non-pipelined: one transfer in flight; address phase registered, read data returned registered with a valid pulse.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width
//  STARVE_LIMIT 4   max consecutive MAU grants while IFU pending before IFU is forced (1..15)
// PORTS
//  clk          in   1       clock; all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  ifu_req      in   1       fetch request; held with ifu_addr until ifu_gnt
//  ifu_addr     in   ADDR_W  fetch address
//  ifu_gnt      out  1       1-cycle pulse: fetch address accepted
//  ifu_rvalid   out  1       1-cycle pulse: ifu_rdata/ifu_err valid
//  ifu_rdata    out  DATA_W  fetched word
//  ifu_err      out  1       bus ERROR on this fetch (qualified by ifu_rvalid)
//  mau_req      in   1       data request; held with mau_* until mau_gnt
//  mau_addr     in   ADDR_W  data address
//  mau_write    in   1       1=store, 0=load
//  mau_size     in   3       HSIZE code (000 byte, 001 half, 010 word)
//  mau_wdata    in   DATA_W  store data
//  mau_gnt      out  1       1-cycle pulse: data request accepted
//  mau_rvalid   out  1       1-cycle pulse: transfer complete (load data or store ack)
//  mau_rdata    out  DATA_W  load data
//  mau_err      out  1       bus ERROR (qualified by mau_rvalid)
//  HADDR        out  ADDR_W  bus address
//  HTRANS       out  2       00 IDLE, 10 NONSEQ only
//  HWRITE       out  1       write strobe
//  HSIZE        out  3       transfer size; fetches always 010
//  HBUST        out  3       tied 000 (SINGLE)
//  HWDATA       out  DATA_W  write data, driven during data phase
//  HRDATA       in   DATA_W  read data
//  HREADY       in   1       transfer/phase complete
//  HRESP        in   2       00 OKAY, 01 ERROR
// BEHAVIOUR
//  Reset: all outputs 0 (HTRANS=IDLE, gnt/rvalid/err low, rdata 0); FSM->IDLE; starve counter 0; takes effect immediately, any in-flight transfer abandoned, no rvalid issued.
//  FSM IDLE: if any req, pick winner, latch addr/write/size/wdata/owner, pulse winner gnt, ->ADDR.
//  ADDR: HTRANS=NONSEQ, HADDR/HWRITE/HSIZE from latch; HREADY=1 -> DATA; HREADY=0 -> hold ADDR, outputs stable.
//  DATA: HTRANS=IDLE, HWDATA=latched wdata; HREADY=1 -> capture HRDATA (loads/fetches) and HRESP, pulse owner rvalid next cycle with err=(HRESP==ERROR), ->IDLE.
//  ERROR: HRESP=01,HREADY=0 cycle is a wait; completion on the following HREADY=1 cycle with err=1.
//  Min latency: req at N, gnt at N, NONSEQ at N+1, data phase N+2 (HREADY=1), rvalid at N+3. Back-to-back issue every 3 cycles.
//  Arbitration (default): MAU priority; starve counter +1 per MAU grant while ifu_req=1, clears on any IFU grant;
//   counter==STARVE_LIMIT and both requesting -> IFU wins. Counter saturates, never wraps.
//  Only one gnt per cycle; no gnt outside IDLE. A req dropped before gnt is ignored (not allowed by protocol; no error flagged).
//  Store completion: mau_rvalid=1, mau_rdata=0. rdata holds last value between pulses.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: when both requesting, winner alternates (last-owner flag, reset to IFU-last so MAU wins first);
//   starve counter not instantiated, STARVE_LIMIT ignored.
//  Undefined: fixed MAU priority with STARVE_LIMIT guard as above.
// STRUCTURE
//  Package riscv_bus_pkg: HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR, HBUST_SINGLE constants;
//   arbiter state encoding (ST_IDLE, ST_ADDR, ST_DATA); owner encoding (OWN_IFU, OWN_MAU).
//  One sub-module arb_pick: combinational winner select + starve counter/RR flag register; FSM and bus regs in top.
// TESTING
//  1 IFU-only fetch 0x0000_0100, HREADY=1 always, HRDATA=0x0000_0013 -> gnt@N, NONSEQ@N+1, ifu_rvalid@N+3 rdata=0x13, err=0.
//  2 MAU store 0x2000_0004 word 0xDEADBEEF, HREADY low 2 cycles in data phase -> HWRITE=1 in ADDR, HWDATA=0xDEADBEEF held through waits, mau_rvalid 1 cycle after HREADY rises.
//  3 Both req continuously, STARVE_LIMIT=4 -> grant order M,M,M,M,I,M,M,M,M,I; with ARB_ROUND_ROBIN_EN -> M,I,M,I.
//  4 MAU load 0x3000_0000 with HRESP=ERROR two-cycle response -> mau_rvalid with mau_err=1, next request served normally.
//  5 Reset asserted in DATA state with HREADY=0 -> outputs 0 same cycle, no rvalid; after release, pending ifu_req granted first cycle.
//  6 Byte load mau_size=000 addr 0x2000_0003 -> HSIZE=000, HADDR=0x2000_0003; ifu_req arriving mid-transfer waits until IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// riscv_bus_pkg: shared constants and encodings for the memory port arbiter.
//   AHB-lite HTRANS / HSIZE / HRESP / HBURST codes used on the external bus,
//   the arbiter FSM state encoding and the transfer-owner encoding.
package riscv_bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HBUST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_MAU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: groups the IFU request port, the MAU request port and
// the AHB-lite master bus of the memory port arbiter.
//   slave  modport: the arbiter's view (requests/HRDATA/HREADY/HRESP in,
//                   grants/responses/bus address phase out)
//   master modport: the environment's view (requesters plus bus slave)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IFU (instruction fetch) port
    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_gnt;
    logic              ifu_rvalid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_err;
    // MAU (data) port
    logic              mau_req;
    logic [ADDR_W-1:0] mau_addr;
    logic              mau_write;
    logic [2:0]        mau_size;
    logic [DATA_W-1:0] mau_wdata;
    logic              mau_gnt;
    logic              mau_rvalid;
    logic [DATA_W-1:0] mau_rdata;
    logic              mau_err;
    // AHB-lite master bus
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBUST;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;

    modport slave (
        input  ifu_req, ifu_addr,
        input  mau_req, mau_addr, mau_write, mau_size, mau_wdata,
        input  HRDATA, HREADY, HRESP,
        output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        output mau_gnt, mau_rvalid, mau_rdata, mau_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBUST, HWDATA
    );

    modport master (
        output ifu_req, ifu_addr,
        output mau_req, mau_addr, mau_write, mau_size, mau_wdata,
        output HRDATA, HREADY, HRESP,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        input  mau_gnt, mau_rvalid, mau_rdata, mau_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBUST, HWDATA
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: winner selection between IFU and MAU for the memory port arbiter.
//   clk, reset        clock, asynchronous active-high reset
//   slot              an arbitration slot is open this cycle (arbiter IDLE)
//   ifu_req, mau_req  requests
//   pick_ifu/pick_mau one-hot grant for this cycle (both 0 when no slot)
// Build option ARB_ROUND_ROBIN_EN: alternate winners on contention instead of
// fixed MAU priority with the STARVE_LIMIT guard.
module arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic slot,
    input  logic ifu_req,
    input  logic mau_req,
    output logic pick_ifu,
    output logic pick_mau
);

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who got the last grant; resets to "IFU was last" so MAU wins
    // the first contention.
    logic last_mau;

    always_comb begin
        pick_ifu = 1'b0;
        pick_mau = 1'b0;
        if (slot) begin
            if (ifu_req && mau_req) begin
                pick_ifu = last_mau;
                pick_mau = !last_mau;
            end else begin
                pick_mau = mau_req;
                pick_ifu = ifu_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         last_mau <= 1'b0;
        else if (pick_mau) last_mau <= 1'b1;
        else if (pick_ifu) last_mau <= 1'b0;
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Consecutive MAU grants taken while the IFU was waiting; saturates.
    logic [3:0] starve_cnt;

    always_comb begin
        pick_ifu = 1'b0;
        pick_mau = 1'b0;
        if (slot) begin
            if (ifu_req && mau_req) begin
                pick_ifu = (starve_cnt >= LIMIT);
                pick_mau = (starve_cnt <  LIMIT);
            end else begin
                pick_mau = mau_req;
                pick_ifu = ifu_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt <= 4'd0;
        else if (pick_ifu)
            starve_cnt <= 4'd0;
        else if (pick_mau && ifu_req && (starve_cnt < LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one non-pipelined AHB-lite master port between the
// instruction fetch requester (IFU) and the data requester (MAU).
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-high reset; abandons any transfer in flight
//   bus    mem_port_arbiter_if.slave: IFU port, MAU port, AHB-lite bus
// One transfer at a time: IDLE (grant) -> ADDR (NONSEQ) -> DATA -> IDLE, with
// the owner's rvalid pulsed the cycle after the data phase completes.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration (see arb_pick).
import riscv_bus_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    arb_state_e        state, state_nxt;
    logic              slot, pick_ifu, pick_mau;

    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    owner_e            owner_q;

    logic              ifu_rvalid_q, mau_rvalid_q, ifu_err_q, mau_err_q;
    logic [DATA_W-1:0] ifu_rdata_q, mau_rdata_q;
    logic              done;

    // Grants are combinational in IDLE; masking with reset keeps gnt low while
    // reset is held even though the FSM already sits in IDLE.
    assign slot = (state == ST_IDLE) && !reset;
    assign done = (state == ST_DATA) && bus.HREADY;

    arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk      (clk),
        .reset    (reset),
        .slot     (slot),
        .ifu_req  (bus.ifu_req),
        .mau_req  (bus.mau_req),
        .pick_ifu (pick_ifu),
        .pick_mau (pick_mau)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWDATA = '0;
        case (state)
            ST_IDLE: if (pick_ifu || pick_mau) state_nxt = ST_ADDR;
            ST_ADDR: begin
                bus.HTRANS = HTRANS_NONSEQ;
                if (bus.HREADY) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                bus.HWDATA = wdata_q;
                if (bus.HREADY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latch: captured at grant, drives the address phase and HWDATA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            wdata_q <= '0;
            owner_q <= OWN_IFU;
        end else if (pick_mau) begin
            addr_q  <= bus.mau_addr;
            write_q <= bus.mau_write;
            size_q  <= bus.mau_size;
            wdata_q <= bus.mau_wdata;
            owner_q <= OWN_MAU;
        end else if (pick_ifu) begin
            addr_q  <= bus.ifu_addr;
            write_q <= 1'b0;
            size_q  <= HSIZE_WORD;
            wdata_q <= '0;
            owner_q <= OWN_IFU;
        end
    end

    // Response registers: rvalid is a one-cycle pulse, rdata/err hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifu_rvalid_q <= 1'b0;
            mau_rvalid_q <= 1'b0;
            ifu_err_q    <= 1'b0;
            mau_err_q    <= 1'b0;
            ifu_rdata_q  <= '0;
            mau_rdata_q  <= '0;
        end else begin
            ifu_rvalid_q <= done && (owner_q == OWN_IFU);
            mau_rvalid_q <= done && (owner_q == OWN_MAU);
            if (done && (owner_q == OWN_IFU)) begin
                ifu_rdata_q <= bus.HRDATA;
                ifu_err_q   <= (bus.HRESP == HRESP_ERROR);
            end
            if (done && (owner_q == OWN_MAU)) begin
                mau_rdata_q <= write_q ? '0 : bus.HRDATA;
                mau_err_q   <= (bus.HRESP == HRESP_ERROR);
            end
        end
    end

    assign bus.ifu_gnt    = pick_ifu;
    assign bus.mau_gnt    = pick_mau;
    assign bus.ifu_rvalid = ifu_rvalid_q;
    assign bus.ifu_rdata  = ifu_rdata_q;
    assign bus.ifu_err    = ifu_err_q;
    assign bus.mau_rvalid = mau_rvalid_q;
    assign bus.mau_rdata  = mau_rdata_q;
    assign bus.mau_err    = mau_err_q;
    assign bus.HADDR      = addr_q;
    assign bus.HWRITE     = write_q;
    assign bus.HSIZE      = size_q;
    assign bus.HBUST      = HBUST_SINGLE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario bench for mem_port_arbiter. Expected responses
// are queued at grant time and popped when an rvalid pulse appears.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_mau;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ifu_req   = 1'b0;
        bus.ifu_addr  = '0;
        bus.mau_req   = 1'b0;
        bus.mau_addr  = '0;
        bus.mau_write = 1'b0;
        bus.mau_size  = 3'b010;
        bus.mau_wdata = '0;
        bus.HRDATA    = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_rvalid(input int max, output bit got);
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            mid();
            if (bus.ifu_rvalid || bus.mau_rvalid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        e  = '0;
        if (ok) e = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.ifu_req = 1'b1;
        tick();
        tick();
        mid();
        checks++; if (bus.HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%0h exp=0", bus.HTRANS); end
        checks++; if (bus.HADDR !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h exp=0", bus.HADDR); end
        checks++; if ({bus.ifu_gnt, bus.mau_gnt} !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", {bus.ifu_gnt, bus.mau_gnt}); end
        checks++; if ({bus.ifu_rvalid, bus.mau_rvalid, bus.ifu_err, bus.mau_err} !== 4'b0) begin failures++; $display("FAIL rst_rvalid_err got=%b exp=0000", {bus.ifu_rvalid, bus.mau_rvalid, bus.ifu_err, bus.mau_err}); end
        checks++; if ({bus.ifu_rdata, bus.mau_rdata} !== 64'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", {bus.ifu_rdata, bus.mau_rdata}); end
        tick();
        bus.ifu_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        exp_t e; bit ok;
        tick();
        bus.ifu_req = 1'b1; bus.ifu_addr = 32'h0000_0100; bus.HRDATA = 32'h0000_0013;
        mid();
        checks++; if ({bus.ifu_gnt, bus.mau_gnt} !== 2'b10) begin failures++; $display("FAIL t1_gnt got=%b exp=10", {bus.ifu_gnt, bus.mau_gnt}); end
        sb.push_back('{is_mau: 1'b0, rdata: 32'h0000_0013, err: 1'b0});
        tick();
        bus.ifu_req = 1'b0;
        mid();
        checks++; if (bus.HTRANS !== 2'b10) begin failures++; $display("FAIL t1_nonseq got=%0h exp=2", bus.HTRANS); end
        checks++; if ({bus.HADDR, bus.HSIZE, bus.HWRITE} !== {32'h0000_0100, 3'b010, 1'b0}) begin failures++; $display("FAIL t1_addr got=%h/%b/%b exp=00000100/010/0", bus.HADDR, bus.HSIZE, bus.HWRITE); end
        tick();
        mid();
        checks++; if ({bus.HTRANS, bus.ifu_rvalid} !== 3'b000) begin failures++; $display("FAIL t1_data_phase got=%b exp=000", {bus.HTRANS, bus.ifu_rvalid}); end
        tick();
        mid();
        pop_exp(e, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t1_sb got=empty exp=entry"); end
        checks++; if ({bus.mau_rvalid, bus.ifu_rvalid} !== {e.is_mau, !e.is_mau}) begin failures++; $display("FAIL t1_rvalid got=%b exp=01", {bus.mau_rvalid, bus.ifu_rvalid}); end
        checks++; if (bus.ifu_rdata !== e.rdata) begin failures++; $display("FAIL t1_rdata got=%h exp=%h", bus.ifu_rdata, e.rdata); end
        checks++; if (bus.ifu_err !== e.err) begin failures++; $display("FAIL t1_err got=%b exp=%b", bus.ifu_err, e.err); end
    endtask

    task automatic test_store_wait();
        exp_t e; bit ok;
        tick();
        bus.mau_req = 1'b1; bus.mau_addr = 32'h2000_0004; bus.mau_write = 1'b1;
        bus.mau_size = 3'b010; bus.mau_wdata = 32'hDEAD_BEEF; bus.HRDATA = 32'h5555_5555;
        mid();
        checks++; if ({bus.ifu_gnt, bus.mau_gnt} !== 2'b01) begin failures++; $display("FAIL t2_gnt got=%b exp=01", {bus.ifu_gnt, bus.mau_gnt}); end
        sb.push_back('{is_mau: 1'b1, rdata: 32'h0, err: 1'b0});
        tick();
        bus.mau_req = 1'b0;
        mid();
        checks++; if ({bus.HTRANS, bus.HWRITE, bus.HADDR} !== {2'b10, 1'b1, 32'h2000_0004}) begin failures++; $display("FAIL t2_addr got=%b/%b/%h exp=10/1/20000004", bus.HTRANS, bus.HWRITE, bus.HADDR); end
        tick();
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++; if (bus.HWDATA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t2_hwdata got=%h exp=deadbeef", bus.HWDATA); end
            checks++; if (bus.mau_rvalid !== 1'b0) begin failures++; $display("FAIL t2_early_rvalid got=%b exp=0", bus.mau_rvalid); end
            tick();
            if (i == 1) bus.HREADY = 1'b1;
        end
        mid();
        pop_exp(e, ok);
        checks++; if (!ok) begin failures++; $display("FAIL t2_sb got=empty exp=entry"); end
        checks++; if ({bus.mau_rvalid, bus.ifu_rvalid} !== {e.is_mau, !e.is_mau}) begin failures++; $display("FAIL t2_rvalid got=%b exp=10", {bus.mau_rvalid, bus.ifu_rvalid}); end
        checks++; if ({bus.mau_rdata, bus.mau_err} !== {e.rdata, e.err}) begin failures++; $display("FAIL t2_resp got=%h/%b exp=%h/%b", bus.mau_rdata, bus.mau_err, e.rdata, e.err); end
        tick();
        mid();
        checks++; if (bus.mau_rvalid !== 1'b0) begin failures++; $display("FAIL t2_pulse got=%b exp=0", bus.mau_rvalid); end
    endtask

    task automatic test_arbitration();
        exp_t e; bit ok; bit got;
        int   n;
        bit   got_order [10];
        bit   exp_order [10];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        do_reset();
        bus.ifu_req = 1'b1; bus.ifu_addr = 32'h0000_0200;
        bus.mau_req = 1'b1; bus.mau_addr = 32'h4000_0000; bus.mau_write = 1'b0;
        bus.HRDATA  = 32'h1234_5678;
        n = 0;
        for (int cyc = 0; cyc < 45 && n < 10; cyc++) begin
            mid();
            if (bus.ifu_rvalid || bus.mau_rvalid) begin
                pop_exp(e, ok);
                checks++; if (!ok || {bus.mau_rvalid, bus.ifu_rvalid} !== {e.is_mau, !e.is_mau}) begin failures++; $display("FAIL t3_rvalid got=%b exp=%b", {bus.mau_rvalid, bus.ifu_rvalid}, {e.is_mau, !e.is_mau}); end
                checks++; if ((e.is_mau ? bus.mau_rdata : bus.ifu_rdata) !== e.rdata) begin failures++; $display("FAIL t3_rdata got=%h exp=%h", e.is_mau ? bus.mau_rdata : bus.ifu_rdata, e.rdata); end
            end
            if (bus.ifu_gnt || bus.mau_gnt) begin
                checks++; if (bus.ifu_gnt && bus.mau_gnt) begin failures++; $display("FAIL t3_onehot got=11 exp=one_gnt"); end
                got_order[n] = bus.mau_gnt;
                sb.push_back('{is_mau: bus.mau_gnt, rdata: 32'h1234_5678, err: 1'b0});
                n++;
            end
            tick();
        end
        bus.ifu_req = 1'b0;
        bus.mau_req = 1'b0;
        checks++; if (n != 10) begin failures++; $display("FAIL t3_grant_count got=%0d exp=10", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got_order[i] !== exp_order[i]) begin failures++; $display("FAIL t3_order[%0d] got_mau=%b exp_mau=%b", i, got_order[i], exp_order[i]); end
        end
        wait_rvalid(10, got);
        checks++; if (!got) begin failures++; $display("FAIL t3_last_rvalid got=timeout exp=pulse"); end
        pop_exp(e, ok);
        checks++; if (!ok || {bus.mau_rvalid, bus.ifu_rvalid} !== {e.is_mau, !e.is_mau}) begin failures++; $display("FAIL t3_last_owner got=%b exp=%b", {bus.mau_rvalid, bus.ifu_rvalid}, {e.is_mau, !e.is_mau}); end
    endtask

    task automatic test_error();
        exp_t e; bit ok; bit got;
        tick();
        bus.mau_req = 1'b1; bus.mau_addr = 32'h3000_0000; bus.mau_write = 1'b0;
        bus.mau_size = 3'b010; bus.HRDATA = 32'h0;
        mid();
        checks++; if (bus.mau_gnt !== 1'b1) begin failures++; $display("FAIL t4_gnt got=%b exp=1", bus.mau_gnt); end
        sb.push_back('{is_mau: 1'b1, rdata: 32'h0, err: 1'b1});
        tick();
        bus.mau_req = 1'b0;
        tick();
        bus.HRESP = 2'b01; bus.HREADY = 1'b0;
        mid();
        checks++; if (bus.mau_rvalid !== 1'b0) begin failures++; $display("FAIL t4_wait_rvalid got=%b exp=0", bus.mau_rvalid); end
        tick();
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP = 2'b00;
        mid();
        pop_exp(e, ok);
        checks++; if (!ok || bus.mau_rvalid !== 1'b1) begin failures++; $display("FAIL t4_rvalid got=%b exp=1", bus.mau_rvalid); end
        checks++; if (bus.mau_err !== e.err) begin failures++; $display("FAIL t4_err got=%b exp=%b", bus.mau_err, e.err); end
        tick();
        bus.ifu_req = 1'b1; bus.ifu_addr = 32'h0000_0104; bus.HRDATA = 32'h0000_0093;
        mid();
        checks++; if (bus.ifu_gnt !== 1'b1) begin failures++; $display("FAIL t4_next_gnt got=%b exp=1", bus.ifu_gnt); end
        sb.push_back('{is_mau: 1'b0, rdata: 32'h0000_0093, err: 1'b0});
        tick();
        bus.ifu_req = 1'b0;
        wait_rvalid(8, got);
        pop_exp(e, ok);
        checks++; if (!got || !ok || bus.ifu_rvalid !== 1'b1) begin failures++; $display("FAIL t4_next_rvalid got=%b exp=1", bus.ifu_rvalid); end
        checks++; if ({bus.ifu_rdata, bus.ifu_err} !== {e.rdata, e.err}) begin failures++; $display("FAIL t4_next_resp got=%h/%b exp=%h/%b", bus.ifu_rdata, bus.ifu_err, e.rdata, e.err); end
    endtask

    task automatic test_reset_mid_transfer();
        exp_t e; bit ok; bit got;
        do_reset();
        bus.mau_req = 1'b1; bus.mau_addr = 32'h5000_0000; bus.mau_write = 1'b0;
        bus.HRDATA = 32'hAAAA_AAAA;
        mid();
        checks++; if (bus.mau_gnt !== 1'b1) begin failures++; $display("FAIL t5_gnt got=%b exp=1", bus.mau_gnt); end
        sb.push_back('{is_mau: 1'b1, rdata: 32'hAAAA_AAAA, err: 1'b0});
        tick();
        bus.mau_req = 1'b0;
        bus.ifu_req = 1'b1; bus.ifu_addr = 32'h0000_0300;
        tick();
        bus.HREADY = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if ({bus.HTRANS, bus.HADDR, bus.HWDATA} !== 66'h0) begin failures++; $display("FAIL t5_bus_zero got=%0h/%h/%h exp=0", bus.HTRANS, bus.HADDR, bus.HWDATA); end
        checks++; if ({bus.ifu_gnt, bus.mau_gnt, bus.ifu_rvalid, bus.mau_rvalid} !== 4'b0) begin failures++; $display("FAIL t5_ctl_zero got=%b exp=0000", {bus.ifu_gnt, bus.mau_gnt, bus.ifu_rvalid, bus.mau_rvalid}); end
        sb.delete();
        bus.HREADY = 1'b1;
        tick();
        mid();
        checks++; if ({bus.ifu_gnt, bus.mau_rvalid} !== 2'b00) begin failures++; $display("FAIL t5_held got=%b exp=00", {bus.ifu_gnt, bus.mau_rvalid}); end
        tick();
        reset = 1'b0;
        bus.HRDATA = 32'h0000_0077;
        mid();
        checks++; if (bus.ifu_gnt !== 1'b1) begin failures++; $display("FAIL t5_post_gnt got=%b exp=1", bus.ifu_gnt); end
        sb.push_back('{is_mau: 1'b0, rdata: 32'h0000_0077, err: 1'b0});
        tick();
        bus.ifu_req = 1'b0;
        wait_rvalid(8, got);
        pop_exp(e, ok);
        checks++; if (!got || !ok || {bus.mau_rvalid, bus.ifu_rvalid} !== {e.is_mau, !e.is_mau}) begin failures++; $display("FAIL t5_rvalid got=%b exp=01", {bus.mau_rvalid, bus.ifu_rvalid}); end
        checks++; if (bus.ifu_rdata !== e.rdata) begin failures++; $display("FAIL t5_rdata got=%h exp=%h", bus.ifu_rdata, e.rdata); end
    endtask

    task automatic test_byte_load_and_late_fetch();
        exp_t e; bit ok; bit got;
        tick();
        bus.mau_req = 1'b1; bus.mau_addr = 32'h2000_0003; bus.mau_write = 1'b0;
        bus.mau_size = 3'b000; bus.HRDATA = 32'h0000_00AB;
        mid();
        checks++; if (bus.mau_gnt !== 1'b1) begin failures++; $display("FAIL t6_gnt got=%b exp=1", bus.mau_gnt); end
        sb.push_back('{is_mau: 1'b1, rdata: 32'h0000_00AB, err: 1'b0});
        tick();
        bus.mau_req = 1'b0;
        bus.ifu_req = 1'b1; bus.ifu_addr = 32'h0000_0400;
        mid();
        checks++; if ({bus.HSIZE, bus.HADDR} !== {3'b000, 32'h2000_0003}) begin failures++; $display("FAIL t6_addr got=%b/%h exp=000/20000003", bus.HSIZE, bus.HADDR); end
        checks++; if (bus.ifu_gnt !== 1'b0) begin failures++; $display("FAIL t6_gnt_in_addr got=%b exp=0", bus.ifu_gnt); end
        tick();
        mid();
        checks++; if (bus.ifu_gnt !== 1'b0) begin failures++; $display("FAIL t6_gnt_in_data got=%b exp=0", bus.ifu_gnt); end
        tick();
        bus.HRDATA = 32'h0000_0113;
        mid();
        pop_exp(e, ok);
        checks++; if (!ok || bus.mau_rvalid !== 1'b1) begin failures++; $display("FAIL t6_rvalid got=%b exp=1", bus.mau_rvalid); end
        checks++; if (bus.mau_rdata !== e.rdata) begin failures++; $display("FAIL t6_rdata got=%h exp=%h", bus.mau_rdata, e.rdata); end
        checks++; if (bus.ifu_gnt !== 1'b1) begin failures++; $display("FAIL t6_late_gnt got=%b exp=1", bus.ifu_gnt); end
        sb.push_back('{is_mau: 1'b0, rdata: 32'h0000_0113, err: 1'b0});
        tick();
        bus.ifu_req = 1'b0;
        mid();
        checks++; if ({bus.HSIZE, bus.HADDR} !== {3'b010, 32'h0000_0400}) begin failures++; $display("FAIL t6_fetch_addr got=%b/%h exp=010/00000400", bus.HSIZE, bus.HADDR); end
        wait_rvalid(8, got);
        pop_exp(e, ok);
        checks++; if (!got || !ok || bus.ifu_rvalid !== 1'b1) begin failures++; $display("FAIL t6_fetch_rvalid got=%b exp=1", bus.ifu_rvalid); end
        checks++; if (bus.ifu_rdata !== e.rdata) begin failures++; $display("FAIL t6_fetch_rdata got=%h exp=%h", bus.ifu_rdata, e.rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_arbitration();
        test_error();
        test_reset_mid_transfer();
        test_byte_load_and_late_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
